// File: rtl/pipe_a_if.sv
// pipe_a_if: operation/result bundle for the pipe_a ALU pipeline.
//   rs1, rs2 : source register indices (4b)
//   rd       : destination register index (4b)
//   func     : ALU function code (4b)
//   addr     : data-memory store address (8b)
//   Z        : registered ALU result from the execute stage (16b)
// master drives the operation and observes Z; slave is the pipeline.
interface pipe_a_if;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic [15:0] Z;

    modport master (
        output rs1, rs2, rd, func, addr,
        input  Z
    );

    modport slave (
        input  rs1, rs2, rd, func, addr,
        output Z
    );
endinterface

// File: rtl/pipe_a.sv
// pipe_a: four-stage register-to-register ALU pipeline.
//   issue/read -> execute -> writeback (regbank) -> store (mem)
// Ports:
//   clk1 : system clock, rising-edge active
//   rst  : asynchronous active-high reset
//   bus  : pipe_a_if.slave (rs1, rs2, rd, func, addr in; Z out)
// No valid bits, stalls or forwarding: every stage acts every cycle, so
// reset bubbles write regbank[0] and mem[0] with zero as they drain.
module pipe_a (
    input  logic     clk1,
    input  logic     rst,
    pipe_a_if.slave  bus
);
    localparam int unsigned DW   = 16;
    localparam int unsigned RW   = 4;
    localparam int unsigned AW   = 8;
    localparam int unsigned NREG = 16;
    localparam int unsigned NMEM = 256;

    logic [DW-1:0] regbank [0:NREG-1];
    logic [DW-1:0] mem     [0:NMEM-1];

    // Stage 1 latches
    logic [DW-1:0] a_q, b_q;
    logic [RW-1:0] rd1_q, func_q;
    logic [AW-1:0] addr1_q;
    // Stage 2 latches
    logic [DW-1:0] z_q, z_d;
    logic [RW-1:0] rd2_q;
    logic [AW-1:0] addr2_q;
    // Stage 3 latches
    logic [DW-1:0] z3_q;
    logic [AW-1:0] addr3_q;

    // ALU, unsigned, results wrap modulo 2^16
    always_comb begin
        z_d = '0;
        case (func_q)
            4'd0:    z_d = a_q + b_q;
            4'd1:    z_d = a_q - b_q;
            4'd2:    z_d = a_q * b_q;
            4'd3:    z_d = a_q;
            4'd4:    z_d = b_q;
            4'd5:    z_d = a_q & b_q;
            4'd6:    z_d = a_q | b_q;
            4'd7:    z_d = a_q ^ b_q;
            4'd8:    z_d = ~a_q;
            4'd9:    z_d = ~b_q;
            4'd10:   z_d = a_q >> 1;
            4'd11:   z_d = a_q << 1;
            default: z_d = '0;
        endcase
    end

    // Pipeline latches; reset flushes all in-flight operations
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            rd1_q   <= '0;
            func_q  <= '0;
            addr1_q <= '0;
            z_q     <= '0;
            rd2_q   <= '0;
            addr2_q <= '0;
            z3_q    <= '0;
            addr3_q <= '0;
        end else begin
            // Reads see the pre-edge regbank: a same-edge writeback is not forwarded
            a_q     <= regbank[bus.rs1];
            b_q     <= regbank[bus.rs2];
            rd1_q   <= bus.rd;
            func_q  <= bus.func;
            addr1_q <= bus.addr;
            z_q     <= z_d;
            rd2_q   <= rd1_q;
            addr2_q <= addr1_q;
            z3_q    <= z_q;
            addr3_q <= addr2_q;
        end
    end

    // Register bank: reset to identity (regbank[k] = k), writeback from stage 3
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regbank[k] <= DW'(k);
            end
        end else begin
            regbank[rd2_q] <= z_q;
        end
    end

    // Data memory is not reset; stage 4 stores every cycle
    always_ff @(posedge clk1) begin
        mem[addr3_q] <= z3_q;
    end

    assign bus.Z = z_q;

endmodule

// File: tb/tb_pipe_a.sv
// tb_pipe_a: scoreboard bench for pipe_a. Each issued operation pushes its
// expected Z; the entry is popped when it reaches the execute stage. A small
// architectural model tracks regbank/mem writeback for end-of-test checks.
module tb_pipe_a;
    logic clk1 = 1'b0;
    logic rst;

    pipe_a_if bus();

    pipe_a dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [15:0] zm;   // model result (used for writeback)
        logic [15:0] zc;   // value Z is required to show
        logic [3:0]  rd;
        logic [7:0]  addr;
        int          id;
    } ent_t;

    ent_t        q[$];
    ent_t        t2, t3;
    logic [15:0] m_rb  [16];
    logic [15:0] m_mem [256];
    bit          m_val [256];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          next_id = 0;

    function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] f);
        logic [31:0] p;
        logic [15:0] r;
        p = 32'(a) * 32'(b);
        case (f)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = p[15:0];
            4'd3:  r = a;
            4'd4:  r = b;
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8:  r = ~a;
            4'd9:  r = ~b;
            4'd10: r = {1'b0, a[15:1]};
            4'd11: r = {a[14:0], 1'b0};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        ent_t z;
        z.zm = '0; z.zc = '0; z.rd = '0; z.addr = '0; z.id = -1;
        q.delete();
        q.push_back(z);
        t2 = z;
        t3 = z;
        for (int k = 0; k < 16; k++) m_rb[k] = 16'(k);
    endtask

    // Drive one operation, clock it in, retire the stage-2 entry and check Z
    task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                         input logic [3:0] f, input logic [7:0] a,
                         input bit use_exp, input logic [15:0] exp);
        ent_t e;
        bus.rs1 = s1; bus.rs2 = s2; bus.rd = d; bus.func = f; bus.addr = a;
        e.zm   = alu(m_rb[s1], m_rb[s2], f);
        e.zc   = use_exp ? exp : e.zm;
        e.rd   = d;
        e.addr = a;
        e.id   = next_id;
        next_id++;
        q.push_back(e);
        @(posedge clk1);
        #1;
        m_mem[t3.addr] = t3.zm;
        m_val[t3.addr] = 1'b1;
        m_rb[t2.rd]    = t2.zm;
        t3 = t2;
        t2 = q.pop_front();
        n_chk++;
        if (bus.Z !== t2.zc) begin
            n_fail++;
            $display("FAIL z_op%0d: Z=%h required %h", t2.id, bus.Z, t2.zc);
        end
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) issue(4'd0, 4'd0, 4'd9, 4'd12, 8'd200, 1'b0, 16'h0);
    endtask

    task automatic check_rb(input int k, input logic [15:0] exp, input string nm);
        n_chk++;
        if (dut.regbank[k] !== exp) begin
            n_fail++;
            $display("FAIL %s: regbank[%0d]=%h required %h", nm, k, dut.regbank[k], exp);
        end
    endtask

    task automatic check_mem(input int k, input logic [15:0] exp, input string nm);
        n_chk++;
        if (dut.mem[k] !== exp) begin
            n_fail++;
            $display("FAIL %s: mem[%0d]=%h required %h", nm, k, dut.mem[k], exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.func = '0; bus.addr = '0;
        #1;
        n_chk++;
        if (bus.Z !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_z: Z=%h required 0000", bus.Z);
        end
        for (int k = 0; k < 16; k++) check_rb(k, 16'(k), "reset_rb");
        @(posedge clk1);
        #1;
        m_mem[0] = 16'h0000;
        m_val[0] = 1'b1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    // Back-to-back ops including same-edge read of a register being written
    task automatic test_back_to_back();
        issue(4'd3,  4'd5,  4'd10, 4'd0,  8'd125, 1'b1, 16'd8);
        issue(4'd3,  4'd8,  4'd12, 4'd2,  8'd126, 1'b1, 16'd24);
        issue(4'd10, 4'd5,  4'd14, 4'd1,  8'd128, 1'b1, 16'd5);
        issue(4'd7,  4'd3,  4'd13, 4'd11, 8'd127, 1'b1, 16'd14);
        issue(4'd10, 4'd5,  4'd15, 4'd1,  8'd129, 1'b1, 16'd3);
        issue(4'd12, 4'd13, 4'(16), 4'd0, 8'd130, 1'b1, 16'd37);
        filler(3);
        check_rb(10, 16'd8,  "b2b_r10");
        check_rb(12, 16'd24, "b2b_r12");
        check_rb(14, 16'd5,  "b2b_r14");
        check_rb(13, 16'd14, "b2b_r13");
        check_rb(15, 16'd3,  "b2b_r15");
        check_rb(0,  16'd37, "b2b_r0_wrap");
        check_mem(125, 16'd8,  "b2b_m125");
        check_mem(126, 16'd24, "b2b_m126");
        check_mem(128, 16'd5,  "b2b_m128");
        check_mem(127, 16'd14, "b2b_m127");
        check_mem(129, 16'd3,  "b2b_m129");
        check_mem(130, 16'd37, "b2b_m130");
    endtask

    // Build r1=0x00F0 and r2=0x0F0F from reset values with spaced dependent ops
    task automatic test_build_operands();
        apply_reset();
        issue(4'd15, 4'd0, 4'd1, 4'd11, 8'd201, 1'b0, 16'h0);
        filler(2);
        for (int i = 0; i < 3; i++) begin
            issue(4'd1, 4'd0, 4'd1, 4'd11, 8'd201, 1'b0, 16'h0);
            filler(2);
        end
        issue(4'd1, 4'd0, 4'd2, 4'd11, 8'd202, 1'b0, 16'h0);
        filler(2);
        for (int i = 0; i < 3; i++) begin
            issue(4'd2, 4'd0, 4'd2, 4'd11, 8'd202, 1'b0, 16'h0);
            filler(2);
        end
        issue(4'd2, 4'd15, 4'd2, 4'd6, 8'd202, 1'b1, 16'h0F0F);
        filler(2);
        check_rb(1, 16'h00F0, "build_r1");
        check_rb(2, 16'h0F0F, "build_r2");
    endtask

    task automatic test_funcs();
        logic [3:0]  fl [12];
        logic [15:0] ex [12];
        fl = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15};
        ex = '{16'h00F0, 16'h0F0F, 16'h0000, 16'h0FFF, 16'h0FFF, 16'hFF0F,
               16'hF0F0, 16'h0078, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 12; i++) issue(4'd1, 4'd2, 4'd9, fl[i], 8'(140 + i), 1'b1, ex[i]);
        filler(3);
        for (int i = 0; i < 12; i++) check_mem(140 + i, ex[i], "func_mem");
    endtask

    // Reset mid-stream discards in-flight ops
    task automatic test_midreset();
        issue(4'd15, 4'd15, 4'd5, 4'd0, 8'd150, 1'b1, 16'd30);
        filler(3);
        check_mem(150, 16'd30, "mid_pre_m150");
        check_rb(5, 16'd30, "mid_pre_r5");
        issue(4'd4, 4'd4, 4'd5, 4'd2, 8'd150, 1'b1, 16'd16);
        filler(1);
        apply_reset();
        filler(3);
        check_rb(5, 16'd5, "mid_r5_discard");
        check_rb(0, 16'd0, "mid_r0_flush");
        check_mem(150, 16'd30, "mid_m150_discard");
    endtask

    task automatic test_model_compare();
        for (int k = 0; k < 16; k++) check_rb(k, m_rb[k], "model_rb");
        for (int k = 0; k < 256; k++) begin
            if (m_val[k]) check_mem(k, m_mem[k], "model_mem");
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.func = '0; bus.addr = '0;
        for (int k = 0; k < 256; k++) m_val[k] = 1'b0;
        model_reset();
        @(posedge clk1);
        #1;
        test_reset();
        test_back_to_back();
        test_model_compare();
        test_build_operands();
        test_funcs();
        test_model_compare();
        test_midreset();
        test_model_compare();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
